// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : ID/EX stage bus: decode-side inputs, forwarding taps, and
//               EX-side operand/control outputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic        inValid;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] imm;
  logic [4:0]  rsIn;
  logic [4:0]  rtIn;
  logic [4:0]  rdIn;
  logic [4:0]  shamtIn;
  logic [2:0]  ALUOpIn;
  logic [4:0]  ctrlIn;
  logic        exMemRegWrite;
  logic [4:0]  exMemRd;
  logic [31:0] exMemResult;
  logic        memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbResult;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [2:0]  ALUOp;
  logic [4:0]  shamt;
  logic [2:0]  ctrlOut;
  logic [4:0]  writeReg;
  logic [31:0] storeData;
  logic        outValid;
  logic        loadUseHazard;

  modport master (
    output stall, flush, inValid, rsData, rtData, imm, rsIn, rtIn, rdIn,
           shamtIn, ALUOpIn, ctrlIn, exMemRegWrite, exMemRd, exMemResult,
           memWbRegWrite, memWbRd, memWbResult,
    input  inputA, inputB, ALUOp, shamt, ctrlOut, writeReg, storeData,
           outValid, loadUseHazard
  );

  modport slave (
    input  stall, flush, inValid, rsData, rtData, imm, rsIn, rtIn, rdIn,
           shamtIn, ALUOpIn, ctrlIn, exMemRegWrite, exMemRd, exMemResult,
           memWbRegWrite, memWbRd, memWbResult,
    output inputA, inputB, ALUOp, shamt, ctrlOut, writeReg, storeData,
           outValid, loadUseHazard
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with operand forwarding and
//               load-use hazard detection.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage (
  input  wire logic     clk,
  input  wire logic     rst_n,
  id_ex_stage_if.slave  bus
);

  logic        r_valid;
  logic [31:0] r_rsData;
  logic [31:0] r_rtData;
  logic [31:0] r_imm;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_writeReg;
  logic [4:0]  r_shamt;
  logic [2:0]  r_aluOp;
  logic        r_aluSrc;
  logic [2:0]  r_ctrl;     // {RegWrite, MemRead, MemWrite}

  logic        w_hazard;
  logic [31:0] w_fwdA;
  logic [31:0] w_fwdB;

  assign w_hazard = r_valid && r_ctrl[1] && bus.inValid && (r_writeReg != 5'd0) &&
                    ((r_writeReg == bus.rsIn) || (r_writeReg == bus.rtIn));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rsData   <= 32'd0;
      r_rtData   <= 32'd0;
      r_imm      <= 32'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_writeReg <= 5'd0;
      r_shamt    <= 5'd0;
      r_aluOp    <= 3'd0;
      r_aluSrc   <= 1'b0;
      r_ctrl     <= 3'd0;
    end else if (bus.flush) begin
      r_valid  <= 1'b0;
      r_aluSrc <= 1'b0;
      r_ctrl   <= 3'd0;
    end else if (!bus.stall) begin
      if (w_hazard) begin
        // Bubble only; upstream re-presents the same instruction next cycle.
        r_valid  <= 1'b0;
        r_aluSrc <= 1'b0;
        r_ctrl   <= 3'd0;
      end else begin
        r_valid    <= bus.inValid;
        r_rsData   <= bus.rsData;
        r_rtData   <= bus.rtData;
        r_imm      <= bus.imm;
        r_rs       <= bus.rsIn;
        r_rt       <= bus.rtIn;
        r_writeReg <= bus.ctrlIn[3] ? bus.rdIn : bus.rtIn;
        r_shamt    <= bus.shamtIn;
        r_aluOp    <= bus.ALUOpIn;
        r_aluSrc   <= bus.inValid & bus.ctrlIn[4];
        r_ctrl     <= bus.inValid ? bus.ctrlIn[2:0] : 3'd0;
      end
    end
  end

  // EX/MEM wins over MEM/WB; register 0 is never a forwarding target.
  always_comb begin
    w_fwdA = r_rsData;
    w_fwdB = r_rtData;
    if (bus.exMemRegWrite && (bus.exMemRd != 5'd0) && (bus.exMemRd == r_rs))
      w_fwdA = bus.exMemResult;
    else if (bus.memWbRegWrite && (bus.memWbRd != 5'd0) && (bus.memWbRd == r_rs))
      w_fwdA = bus.memWbResult;
    if (bus.exMemRegWrite && (bus.exMemRd != 5'd0) && (bus.exMemRd == r_rt))
      w_fwdB = bus.exMemResult;
    else if (bus.memWbRegWrite && (bus.memWbRd != 5'd0) && (bus.memWbRd == r_rt))
      w_fwdB = bus.memWbResult;
  end

  assign bus.inputA        = w_fwdA;
  assign bus.inputB        = r_aluSrc ? r_imm : w_fwdB;
  assign bus.storeData     = w_fwdB;
  assign bus.ALUOp         = r_aluOp;
  assign bus.shamt         = r_shamt;
  assign bus.writeReg      = r_writeReg;
  assign bus.ctrlOut       = r_ctrl & {3{r_valid}};
  assign bus.outValid      = r_valid;
  assign bus.loadUseHazard = w_hazard;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed and randomized self-checking bench for id_ex_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic set_idle();
    bus.stall = 0; bus.flush = 0; bus.inValid = 0;
    bus.rsData = 0; bus.rtData = 0; bus.imm = 0;
    bus.rsIn = 0; bus.rtIn = 0; bus.rdIn = 0; bus.shamtIn = 0;
    bus.ALUOpIn = 0; bus.ctrlIn = 0;
    bus.exMemRegWrite = 0; bus.exMemRd = 0; bus.exMemResult = 0;
    bus.memWbRegWrite = 0; bus.memWbRd = 0; bus.memWbResult = 0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    #12;
    checks += 4;
    if (bus.outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.outValid); end
    if (bus.ctrlOut !== 3'd0) begin failures++; $display("FAIL reset_ctrl got=%0b exp=000", bus.ctrlOut); end
    if (bus.ALUOp !== 3'd0) begin failures++; $display("FAIL reset_aluop got=%0b exp=000", bus.ALUOp); end
    if (bus.writeReg !== 5'd0) begin failures++; $display("FAIL reset_wreg got=%0d exp=0", bus.writeReg); end
    @(posedge clk); #3; rst_n = 1'b1;
    clk_step();
  endtask

  task automatic test_capture();
    set_idle();
    bus.inValid = 1; bus.rsIn = 1; bus.rtIn = 2; bus.rdIn = 9;
    bus.rsData = 5; bus.rtData = 7; bus.ALUOpIn = 3'b000; bus.ctrlIn = 5'b01100;
    bus.shamtIn = 5'd17;
    clk_step();
    checks += 6;
    if (bus.inputA !== 32'd5) begin failures++; $display("FAIL cap_inputA got=%0h exp=5", bus.inputA); end
    if (bus.inputB !== 32'd7) begin failures++; $display("FAIL cap_inputB got=%0h exp=7", bus.inputB); end
    if (bus.outValid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%0b exp=1", bus.outValid); end
    if (bus.ctrlOut !== 3'b100) begin failures++; $display("FAIL cap_ctrl got=%0b exp=100", bus.ctrlOut); end
    if (bus.writeReg !== 5'd9) begin failures++; $display("FAIL cap_wreg got=%0d exp=9", bus.writeReg); end
    if (bus.shamt !== 5'd17) begin failures++; $display("FAIL cap_shamt got=%0d exp=17", bus.shamt); end
    // Immediate operand path with RegDst=0
    bus.ctrlIn = 5'b10100; bus.imm = 32'h1234; bus.ALUOpIn = 3'b101;
    clk_step();
    checks += 4;
    if (bus.inputB !== 32'h1234) begin failures++; $display("FAIL imm_inputB got=%0h exp=1234", bus.inputB); end
    if (bus.storeData !== 32'd7) begin failures++; $display("FAIL imm_store got=%0h exp=7", bus.storeData); end
    if (bus.writeReg !== 5'd2) begin failures++; $display("FAIL imm_wreg got=%0d exp=2", bus.writeReg); end
    if (bus.ALUOp !== 3'b101) begin failures++; $display("FAIL imm_aluop got=%0b exp=101", bus.ALUOp); end
  endtask

  task automatic test_forward_priority();
    set_idle();
    bus.inValid = 1; bus.rsIn = 3; bus.rtIn = 3; bus.rsData = 32'h11; bus.rtData = 32'h22;
    bus.ctrlIn = 5'b01100; bus.rdIn = 6;
    clk_step();
    bus.inValid = 0;
    bus.exMemRegWrite = 1; bus.exMemRd = 3; bus.exMemResult = 32'hAA;
    bus.memWbRegWrite = 1; bus.memWbRd = 3; bus.memWbResult = 32'hBB;
    #1;
    checks += 2;
    if (bus.inputA !== 32'hAA) begin failures++; $display("FAIL fwd_exmem got=%0h exp=aa", bus.inputA); end
    if (bus.storeData !== 32'hAA) begin failures++; $display("FAIL fwd_exmem_rt got=%0h exp=aa", bus.storeData); end
    bus.exMemRegWrite = 0;
    #1;
    checks += 2;
    if (bus.inputA !== 32'hBB) begin failures++; $display("FAIL fwd_memwb got=%0h exp=bb", bus.inputA); end
    if (bus.inputB !== 32'hBB) begin failures++; $display("FAIL fwd_memwb_rt got=%0h exp=bb", bus.inputB); end
    bus.memWbRegWrite = 0;
    #1;
    checks++;
    if (bus.inputA !== 32'h11) begin failures++; $display("FAIL fwd_none got=%0h exp=11", bus.inputA); end
  endtask

  task automatic test_r0_guard();
    set_idle();
    bus.inValid = 1; bus.rsIn = 0; bus.rtIn = 0; bus.rsData = 32'h55; bus.rtData = 32'h66;
    bus.ctrlIn = 5'b01100; bus.rdIn = 7;
    clk_step();
    bus.exMemRegWrite = 1; bus.exMemRd = 0; bus.exMemResult = 32'hFFFF;
    bus.memWbRegWrite = 1; bus.memWbRd = 0; bus.memWbResult = 32'hEEEE;
    #1;
    checks += 2;
    if (bus.inputA !== 32'h55) begin failures++; $display("FAIL r0_inputA got=%0h exp=55", bus.inputA); end
    if (bus.storeData !== 32'h66) begin failures++; $display("FAIL r0_store got=%0h exp=66", bus.storeData); end
  endtask

  task automatic test_load_use();
    set_idle();
    bus.inValid = 1; bus.ctrlIn = 5'b10110; bus.rsIn = 1; bus.rtIn = 4; bus.rdIn = 9;
    clk_step();
    checks += 2;
    if (bus.writeReg !== 5'd4) begin failures++; $display("FAIL lw_wreg got=%0d exp=4", bus.writeReg); end
    if (bus.ctrlOut !== 3'b110) begin failures++; $display("FAIL lw_ctrl got=%0b exp=110", bus.ctrlOut); end
    bus.inValid = 1; bus.rsIn = 4; bus.rtIn = 5; bus.rdIn = 8; bus.ctrlIn = 5'b01100;
    #1;
    checks++;
    if (bus.loadUseHazard !== 1'b1) begin failures++; $display("FAIL lu_hazard got=%0b exp=1", bus.loadUseHazard); end
    clk_step();
    checks += 3;
    if (bus.outValid !== 1'b0) begin failures++; $display("FAIL lu_bubble_valid got=%0b exp=0", bus.outValid); end
    if (bus.ctrlOut !== 3'd0) begin failures++; $display("FAIL lu_bubble_ctrl got=%0b exp=000", bus.ctrlOut); end
    if (bus.loadUseHazard !== 1'b0) begin failures++; $display("FAIL lu_clear got=%0b exp=0", bus.loadUseHazard); end
    clk_step();
    checks += 2;
    if (bus.outValid !== 1'b1) begin failures++; $display("FAIL lu_replay_valid got=%0b exp=1", bus.outValid); end
    if (bus.writeReg !== 5'd8) begin failures++; $display("FAIL lu_replay_wreg got=%0d exp=8", bus.writeReg); end
    // Load into r0 never creates a hazard
    bus.ctrlIn = 5'b10110; bus.rtIn = 0; bus.rsIn = 2;
    clk_step();
    bus.ctrlIn = 5'b01100; bus.rsIn = 0; bus.rtIn = 0;
    #1;
    checks++;
    if (bus.loadUseHazard !== 1'b0) begin failures++; $display("FAIL lu_r0 got=%0b exp=0", bus.loadUseHazard); end
  endtask

  task automatic test_flush_stall();
    set_idle();
    bus.inValid = 1; bus.rsIn = 1; bus.rsData = 32'h77; bus.rdIn = 10; bus.ctrlIn = 5'b01101;
    clk_step();
    bus.stall = 1; bus.rsData = 32'h99; bus.rdIn = 11; bus.ctrlIn = 5'b01010;
    clk_step();
    checks += 3;
    if (bus.inputA !== 32'h77) begin failures++; $display("FAIL stall_inputA got=%0h exp=77", bus.inputA); end
    if (bus.writeReg !== 5'd10) begin failures++; $display("FAIL stall_wreg got=%0d exp=10", bus.writeReg); end
    if (bus.ctrlOut !== 3'b101) begin failures++; $display("FAIL stall_ctrl got=%0b exp=101", bus.ctrlOut); end
    bus.flush = 1;
    clk_step();
    checks += 2;
    if (bus.outValid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", bus.outValid); end
    if (bus.ctrlOut !== 3'd0) begin failures++; $display("FAIL flush_ctrl got=%0b exp=000", bus.ctrlOut); end
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic test_async_reset();
    set_idle();
    bus.inValid = 1; bus.ctrlIn = 5'b01110; bus.ALUOpIn = 3'b111; bus.rdIn = 12;
    clk_step();
    #3; rst_n = 1'b0; #1;
    checks += 4;
    if (bus.outValid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0b exp=0", bus.outValid); end
    if (bus.ctrlOut !== 3'd0) begin failures++; $display("FAIL arst_ctrl got=%0b exp=000", bus.ctrlOut); end
    if (bus.ALUOp !== 3'd0) begin failures++; $display("FAIL arst_aluop got=%0b exp=000", bus.ALUOp); end
    if (bus.writeReg !== 5'd0) begin failures++; $display("FAIL arst_wreg got=%0d exp=0", bus.writeReg); end
    bus.stall = 1;
    #2; rst_n = 1'b1;
    clk_step();
    checks++;
    if (bus.outValid !== 1'b0) begin failures++; $display("FAIL arst_stall_valid got=%0b exp=0", bus.outValid); end
    bus.stall = 0;
    clk_step();
    checks += 2;
    if (bus.outValid !== 1'b1) begin failures++; $display("FAIL arst_resume_valid got=%0b exp=1", bus.outValid); end
    if (bus.ALUOp !== 3'b111) begin failures++; $display("FAIL arst_resume_aluop got=%0b exp=111", bus.ALUOp); end
  endtask

  task automatic test_random();
    // Reference model: contents of the instruction currently held in EX
    bit          m_valid = 0;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_dst, m_sh;
    logic [2:0]  m_op, m_ctrl;
    bit          m_alusrc;
    logic [31:0] e_a, e_rt;
    bit          e_haz;
    set_idle();
    bus.flush = 1;
    clk_step();
    for (int n = 0; n < 400; n++) begin
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.inValid = ($urandom_range(0, 3) != 0);
      bus.rsData = $urandom; bus.rtData = $urandom; bus.imm = $urandom;
      bus.rsIn = 5'($urandom_range(0, 4)); bus.rtIn = 5'($urandom_range(0, 4));
      bus.rdIn = 5'($urandom_range(0, 4)); bus.shamtIn = 5'($urandom);
      bus.ALUOpIn = 3'($urandom); bus.ctrlIn = 5'($urandom);
      bus.exMemRegWrite = 1'($urandom); bus.exMemRd = 5'($urandom_range(0, 4));
      bus.exMemResult = $urandom;
      bus.memWbRegWrite = 1'($urandom); bus.memWbRd = 5'($urandom_range(0, 4));
      bus.memWbResult = $urandom;
      #1;
      e_haz = m_valid && m_ctrl[1] && bus.inValid && m_dst != 0 &&
              (m_dst == bus.rsIn || m_dst == bus.rtIn);
      e_a  = m_rsd;
      e_rt = m_rtd;
      if (m_rs != 0 && bus.exMemRegWrite && bus.exMemRd == m_rs) e_a = bus.exMemResult;
      else if (m_rs != 0 && bus.memWbRegWrite && bus.memWbRd == m_rs) e_a = bus.memWbResult;
      if (m_rt != 0 && bus.exMemRegWrite && bus.exMemRd == m_rt) e_rt = bus.exMemResult;
      else if (m_rt != 0 && bus.memWbRegWrite && bus.memWbRd == m_rt) e_rt = bus.memWbResult;
      checks += 3;
      if (bus.loadUseHazard !== e_haz) begin failures++; $display("FAIL rnd_hazard n=%0d got=%0b exp=%0b", n, bus.loadUseHazard, e_haz); end
      if (bus.outValid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, bus.outValid, m_valid); end
      if (bus.ctrlOut !== (m_valid ? m_ctrl : 3'd0)) begin failures++; $display("FAIL rnd_ctrl n=%0d got=%0b exp=%0b", n, bus.ctrlOut, m_ctrl); end
      if (m_valid) begin
        checks += 6;
        if (bus.inputA !== e_a) begin failures++; $display("FAIL rnd_inputA n=%0d got=%0h exp=%0h", n, bus.inputA, e_a); end
        if (bus.inputB !== (m_alusrc ? m_imm : e_rt)) begin failures++; $display("FAIL rnd_inputB n=%0d got=%0h exp=%0h", n, bus.inputB, m_alusrc ? m_imm : e_rt); end
        if (bus.storeData !== e_rt) begin failures++; $display("FAIL rnd_store n=%0d got=%0h exp=%0h", n, bus.storeData, e_rt); end
        if (bus.ALUOp !== m_op) begin failures++; $display("FAIL rnd_aluop n=%0d got=%0b exp=%0b", n, bus.ALUOp, m_op); end
        if (bus.shamt !== m_sh) begin failures++; $display("FAIL rnd_shamt n=%0d got=%0d exp=%0d", n, bus.shamt, m_sh); end
        if (bus.writeReg !== m_dst) begin failures++; $display("FAIL rnd_wreg n=%0d got=%0d exp=%0d", n, bus.writeReg, m_dst); end
      end
      @(posedge clk);
      if (bus.flush || (!bus.stall && e_haz)) begin
        m_valid = 0;
        m_ctrl  = 0;
      end else if (!bus.stall) begin
        m_valid  = bus.inValid;
        m_rsd    = bus.rsData;  m_rtd = bus.rtData; m_imm = bus.imm;
        m_rs     = bus.rsIn;    m_rt  = bus.rtIn;
        m_dst    = bus.ctrlIn[3] ? bus.rdIn : bus.rtIn;
        m_sh     = bus.shamtIn; m_op  = bus.ALUOpIn;
        m_alusrc = bus.ctrlIn[4];
        m_ctrl   = bus.inValid ? bus.ctrlIn[2:0] : 3'd0;
      end
      #1;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_capture();
    test_forward_priority();
    test_r0_guard();
    test_load_use();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 No parameters; all datapath widths fixed at 32 bits, register specifiers at 5 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold all stage registers this cycle.
REQ-005 flush  input  1  replace stage contents with a bubble.
REQ-006 inValid  input  1  ID-side instruction present.
REQ-007 rsData  input  32  register-file read port 1 value.
REQ-008 rtData  input  32  register-file read port 2 value.
REQ-009 imm  input  32  sign/zero-extended immediate.
REQ-010 rsIn  input  5  rs specifier.
REQ-011 rtIn  input  5  rt specifier.
REQ-012 rdIn  input  5  rd specifier.
REQ-013 shamtIn  input  5  shift amount field.
REQ-014 ALUOpIn  input  3  ALU operation code, passed through unchanged.
REQ-015 ctrlIn  input  5  {ALUSrc, RegDst, RegWrite, MemRead, MemWrite}.
REQ-016 exMemRegWrite  input  1  EX/MEM instruction writes a register.
REQ-017 exMemRd  input  5  EX/MEM destination register.
REQ-018 exMemResult  input  32  EX/MEM result value.
REQ-019 memWbRegWrite  input  1  MEM/WB instruction writes a register.
REQ-020 memWbRd  input  5  MEM/WB destination register.
REQ-021 memWbResult  input  32  MEM/WB writeback value.
REQ-022 inputA  output  32  forwarded ALU operand A.
REQ-023 inputB  output  32  ALU operand B (forwarded rt or registered imm).
REQ-024 ALUOp  output  3  registered ALU operation code.
REQ-025 shamt  output  5  registered shift amount.
REQ-026 ctrlOut  output  3  registered {RegWrite, MemRead, MemWrite}, all zero when outValid=0.
REQ-027 writeReg  output  5  registered destination, rdIn if RegDst=1 else rtIn.
REQ-028 storeData  output  32  forwarded rt value for stores.
REQ-029 outValid  output  1  stage holds a real instruction.
REQ-030 loadUseHazard  output  1  combinational request for upstream to stall.

Function
REQ-031 Edge priority SHALL be: flush > stall > hazard bubble > capture.
REQ-032 flush=1 SHALL clear outValid and every ctrl bit at the next edge, even when stall=1.
REQ-033 stall=1 with flush=0 SHALL hold every register unchanged.
REQ-034 loadUseHazard=1 with stall=0 and flush=0 SHALL load a bubble (outValid=0, ctrl=0); the upstream stage repeats the instruction.
REQ-035 Otherwise the edge SHALL capture all inputs; outValid<=inValid, and ctrl bits are forced to 0 when inValid=0.
REQ-036 loadUseHazard SHALL be 1 iff outValid & registered MemRead & inValid & registered writeReg!=0 & (writeReg==rsIn | writeReg==rtIn).
REQ-037 Forwarding SHALL be combinational on registered rs/rt: an EX/MEM match (RegWrite=1, Rd nonzero and equal) takes priority over a MEM/WB match; with no match the registered register-file value is used.
REQ-038 Register 0 SHALL never be forwarded.
REQ-039 inputB SHALL be the registered imm when registered ALUSrc=1; otherwise it is the forwarded rt value. storeData SHALL always be the forwarded rt value.
REQ-040 Data outputs are don't-care when outValid=0; ctrlOut SHALL be 0 whenever outValid=0.

Reset
REQ-041 rst_n low SHALL immediately clear all registers to 0 (outValid=0, ctrlOut=0, ALUOp=000, writeReg=0) regardless of clk.
REQ-042 Deasserting rst_n mid-stall SHALL leave the stage empty; the first edge with stall=0 captures normally.

Verification
REQ-043 Capture: rsData=5, rtData=7, ALUOpIn=000, ALUSrc=0, no forwarding -> next cycle inputA=5, inputB=7, outValid=1.
REQ-044 Forward priority: rs=3, exMemRd=3 (result 0xAA), memWbRd=3 (result 0xBB) -> inputA=0xAA; drop exMemRegWrite -> inputA=0xBB.
REQ-045 R0 guard: rs=0, exMemRd=0, exMemRegWrite=1, exMemResult=0xFFFF -> inputA=rsData.
REQ-046 Load-use: registered lw with writeReg=4, incoming rsIn=4 -> loadUseHazard=1, next cycle outValid=0, ctrlOut=000.
REQ-047 Flush beats stall: stall=1, flush=1 -> next cycle outValid=0; async rst_n pulse mid-cycle -> outputs 0 before the next edge.
